// File: rtl/sobel_frame_ctrl_if.sv
// Shared memory port between the frame sequencer and the memory.
// One request (read or write) is outstanding at a time and completes on mem_ack.
interface sobel_frame_ctrl_if #(
  parameter int PIX_W = 8
) ();
  logic             mem_ren;
  logic             mem_wen;
  logic [31:0]      mem_addr;
  logic [PIX_W-1:0] mem_wdata;
  logic [PIX_W-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel core: walks the input image in raster order
// over one memory port, feeds pixels to the line-buffer datapath, and writes
// each edge result back to the centre pixel of every complete 3x3 window.
module sobel_frame_ctrl #(
  parameter int PIX_W = 8,
  parameter int DIM_W = 12
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [DIM_W-1:0]     width,
  input  logic [DIM_W-1:0]     length,
  input  logic [7:0]           initial_addr_r,
  input  logic [7:0]           initial_addr_w,
  sobel_frame_ctrl_if.master   bus,
  output logic [PIX_W-1:0]     pix_data,
  output logic                 pix_valid,
  output logic                 win_valid,
  input  logic [PIX_W-1:0]     edge_data,
  input  logic                 edge_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);
  localparam int IW = 2 * DIM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EDGE,
    S_WR,
    S_DONE
  } state_t;

  state_t           state_q, state_d;

  // frame configuration captured at start
  logic [DIM_W-1:0] w_q;
  logic [IW-1:0]    last_q;
  logic [7:0]       rpage_q, wpage_q;

  // raster position of the pixel being read, and the pending write target
  logic [DIM_W-1:0] x_q, y_q, x_nx, y_nx;
  logic [IW-1:0]    idx_q, idx_nx, cidx_q;
  logic [PIX_W-1:0] wdata_q;

  logic             cfg_ok, is_last, win_hit;
  logic             ren, wen;

  assign cfg_ok  = (width >= DIM_W'(3)) && (length >= DIM_W'(3));
  assign is_last = (idx_q == last_q);
  assign win_hit = (x_q >= DIM_W'(2)) && (y_q >= DIM_W'(2));

  // raster advance: next column, wrapping to the start of the next row
  always_comb begin
    x_nx   = x_q + 1'b1;
    y_nx   = y_q;
    idx_nx = idx_q + 1'b1;
    if (x_q == w_q - 1'b1) begin
      x_nx = '0;
      y_nx = y_q + 1'b1;
    end
  end

  // state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state and request/status decode
  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    wen     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) state_d = S_RD;
      end
      S_RD: begin
        busy = 1'b1;
        ren  = 1'b1;
        if (bus.mem_ack) begin
          if (win_hit)      state_d = S_EDGE;
          else if (is_last) state_d = S_DONE;
        end
      end
      S_EDGE: begin
        busy = 1'b1;
        if (edge_valid) state_d = S_WR;
      end
      S_WR: begin
        busy = 1'b1;
        wen  = 1'b1;
        if (bus.mem_ack) state_d = is_last ? S_DONE : S_RD;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // memory port: address is the page in the top byte OR'd with the pixel index
  assign bus.mem_ren   = ren;
  assign bus.mem_wen   = wen;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_addr  = ren ? ({rpage_q, 24'b0} | 32'(idx_q)) :
                         wen ? ({wpage_q, 24'b0} | 32'(cidx_q)) : 32'b0;

  // config latch, raster counters, pixel/window strobes and edge result capture
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      w_q       <= '0;
      last_q    <= '0;
      rpage_q   <= '0;
      wpage_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      cidx_q    <= '0;
      wdata_q   <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      win_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      win_valid <= 1'b0;
      cfg_err   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_q     <= width;
              last_q  <= IW'(width) * IW'(length) - 1'b1;
              rpage_q <= initial_addr_r;
              wpage_q <= initial_addr_w;
              x_q     <= '0;
              y_q     <= '0;
              idx_q   <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (bus.mem_ack) begin
            pix_data  <= bus.mem_rdata;
            pix_valid <= 1'b1;
            if (win_hit) begin
              // centre of the window whose bottom-right pixel just arrived
              cidx_q    <= idx_q - IW'(w_q) - 1'b1;
              win_valid <= 1'b1;
            end else if (!is_last) begin
              x_q   <= x_nx;
              y_q   <= y_nx;
              idx_q <= idx_nx;
            end
          end
        end
        S_EDGE: begin
          if (edge_valid) wdata_q <= edge_data;
        end
        S_WR: begin
          // counters held through EDGE/WR so the window pixel advances only now
          if (bus.mem_ack && !is_last) begin
            x_q   <= x_nx;
            y_q   <= y_nx;
            idx_q <= idx_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: memory and edge responders with
// configurable latency, a negedge monitor logging all traffic, and per-frame
// checks against hand-derived read/write sequences.
module tb_sobel_frame_ctrl;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [11:0] width, length;
  logic [7:0]  initial_addr_r, initial_addr_w;
  logic [7:0]  pix_data, edge_data;
  logic        pix_valid, win_valid, edge_valid, busy, done, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  // responder configuration
  bit ack_tied = 1'b1, ev_tied = 1'b1;
  int ack_dly = 0, ev_dly = 0;
  logic ack_q, ev_q;
  int   ack_cnt, ev_cnt;

  sobel_frame_ctrl_if #(.PIX_W(8)) bus ();

  sobel_frame_ctrl #(.PIX_W(8), .DIM_W(12)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .width(width), .length(length),
    .initial_addr_r(initial_addr_r), .initial_addr_w(initial_addr_w),
    .bus(bus),
    .pix_data(pix_data), .pix_valid(pix_valid), .win_valid(win_valid),
    .edge_data(edge_data), .edge_valid(edge_valid),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [7:0] rd_fn(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ 8'h5A;
  endfunction

  assign bus.mem_rdata = rd_fn(bus.mem_addr);
  assign bus.mem_ack   = ack_tied ? 1'b1 : ack_q;
  assign edge_valid    = ev_tied ? 1'b1 : ev_q;

  // memory: ack after ack_dly cycles of a held request
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ack_q <= 1'b0; ack_cnt <= 0;
    end else if (ack_q) begin
      ack_q <= 1'b0; ack_cnt <= 0;
    end else if (bus.mem_ren || bus.mem_wen) begin
      if (ack_cnt >= ack_dly) ack_q <= 1'b1;
      else ack_cnt <= ack_cnt + 1;
    end
  end

  // datapath: edge_valid ev_dly cycles after win_valid
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ev_q <= 1'b0; ev_cnt <= 0;
    end else if (ev_q) begin
      ev_q <= 1'b0;
    end else if (win_valid) begin
      ev_cnt <= 1;
    end else if (ev_cnt != 0) begin
      if (ev_cnt >= ev_dly) begin ev_q <= 1'b1; ev_cnt <= 0; end
      else ev_cnt <= ev_cnt + 1;
    end
  end

  // traffic log (only this block writes it)
  logic [31:0] rd_q[$], wr_addr_q[$];
  logic [7:0]  wr_data_q[$], pix_q[$];
  int          wr_nrd_q[$], win_q[$];
  int          n_done = 0, n_done_busy = 0, n_cfg = 0, n_busy = 0;
  int          n_stab = 0, n_ovl = 0, n_ren = 0, n_wen = 0;
  logic        p_ren = 0, p_wen = 0, p_ack = 0;
  logic [31:0] p_addr = 0;
  logic [7:0]  p_wdata = 0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      p_ren = 1'b0; p_wen = 1'b0;
    end else begin
      if (bus.mem_ren && bus.mem_wen) n_ovl++;
      if (bus.mem_ren) n_ren++;
      if (bus.mem_wen) n_wen++;
      if (busy) n_busy++;
      if (cfg_err) n_cfg++;
      if (done) begin n_done++; if (busy) n_done_busy++; end
      if (p_ren && !p_ack && (!bus.mem_ren || bus.mem_addr != p_addr)) n_stab++;
      if (p_wen && !p_ack && (!bus.mem_wen || bus.mem_addr != p_addr ||
                              bus.mem_wdata != p_wdata)) n_stab++;
      if (pix_valid) pix_q.push_back(pix_data);
      if (win_valid) win_q.push_back(rd_q.size());
      if (bus.mem_ren && bus.mem_ack) rd_q.push_back(bus.mem_addr);
      if (bus.mem_wen && bus.mem_ack) begin
        wr_addr_q.push_back(bus.mem_addr);
        wr_data_q.push_back(bus.mem_wdata);
        wr_nrd_q.push_back(rd_q.size());
      end
      p_ren = bus.mem_ren; p_wen = bus.mem_wen; p_ack = bus.mem_ack;
      p_addr = bus.mem_addr; p_wdata = bus.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [54:0] outs();
    return {bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_wdata, pix_data,
            pix_valid, win_valid, busy, done, cfg_err};
  endfunction

  // one frame with given latencies; perturb scrambles config and pulses start mid-frame
  task automatic run_frame(input string nm, input int w, input int l,
                           input logic [7:0] rp, input logic [7:0] wp,
                           input int adly, input int edly, input logic [7:0] ed,
                           input bit perturb);
    int b_rd, b_wr, b_pix, b_win, b_done, b_db, b_busy, b_stab, b_ovl;
    int nw, k, ridx;
    bit got_done;
    @(negedge HCLK);
    ack_tied = (adly == 0); ack_dly = adly;
    ev_tied  = (edly == 0); ev_dly  = edly;
    edge_data = ed;
    b_rd = rd_q.size(); b_wr = wr_addr_q.size(); b_pix = pix_q.size();
    b_win = win_q.size(); b_done = n_done; b_db = n_done_busy;
    b_busy = n_busy; b_stab = n_stab; b_ovl = n_ovl;
    width = 12'(w); length = 12'(l);
    initial_addr_r = rp; initial_addr_w = wp;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    chk({nm, "_busy_start"}, 64'(busy), 64'(1));
    got_done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      @(negedge HCLK);
      if (perturb && cyc == 3) begin
        width = 12'd7; length = 12'd9;
        initial_addr_r = 8'h55; initial_addr_w = 8'h66;
        start = 1'b1;
      end else if (perturb && cyc == 8) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 64'(got_done), 64'(1));
    repeat (4) @(negedge HCLK);
    nw = (w - 2) * (l - 2);
    chk({nm, "_nreads"}, 64'(rd_q.size() - b_rd), 64'(w * l));
    chk({nm, "_npix"}, 64'(pix_q.size() - b_pix), 64'(w * l));
    for (int i = 0; i < w * l && b_rd + i < rd_q.size() && b_pix + i < pix_q.size(); i++) begin
      chk($sformatf("%s_rd_addr[%0d]", nm, i), 64'(rd_q[b_rd + i]), 64'({rp, 24'h0} + i));
      chk($sformatf("%s_pix[%0d]", nm, i), 64'(pix_q[b_pix + i]),
          64'(rd_fn({rp, 24'h0} + i)));
    end
    chk({nm, "_nwrites"}, 64'(wr_addr_q.size() - b_wr), 64'(nw));
    chk({nm, "_nwin"}, 64'(win_q.size() - b_win), 64'(nw));
    k = 0;
    for (int cy = 1; cy < l - 1; cy++) begin
      for (int cx = 1; cx < w - 1; cx++) begin
        ridx = (cy + 1) * w + cx + 1;
        if (b_wr + k < wr_addr_q.size() && b_win + k < win_q.size()) begin
          chk($sformatf("%s_wr_addr[%0d]", nm, k), 64'(wr_addr_q[b_wr + k]),
              64'({wp, 24'h0} + cy * w + cx));
          chk($sformatf("%s_wr_data[%0d]", nm, k), 64'(wr_data_q[b_wr + k]), 64'(ed));
          chk($sformatf("%s_wr_after[%0d]", nm, k), 64'(wr_nrd_q[b_wr + k] - b_rd), 64'(ridx + 1));
          chk($sformatf("%s_win_after[%0d]", nm, k), 64'(win_q[b_win + k] - b_rd), 64'(ridx + 1));
        end
        k++;
      end
    end
    chk({nm, "_ndone"}, 64'(n_done - b_done), 64'(1));
    chk({nm, "_busy_at_done"}, 64'(n_done_busy - b_db), 64'(0));
    chk({nm, "_busy_after"}, 64'(busy), 64'(0));
    chk({nm, "_stable"}, 64'(n_stab - b_stab), 64'(0));
    chk({nm, "_overlap"}, 64'(n_ovl - b_ovl), 64'(0));
    if (adly == 0 && edly == 0)
      chk({nm, "_busy_cycles"}, 64'(n_busy - b_busy), 64'(w * l + 2 * nw));
  endtask

  // rejected configuration: cfg_err one cycle after start, no traffic
  task automatic run_bad(input string nm, input int w, input int l);
    int b_ren, b_wen, b_busy, b_cfg;
    @(negedge HCLK);
    b_ren = n_ren; b_wen = n_wen; b_busy = n_busy; b_cfg = n_cfg;
    width = 12'(w); length = 12'(l);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    chk({nm, "_cfg_err_hi"}, 64'(cfg_err), 64'(1));
    @(negedge HCLK);
    chk({nm, "_cfg_err_lo"}, 64'(cfg_err), 64'(0));
    repeat (4) @(negedge HCLK);
    chk({nm, "_no_ren"}, 64'(n_ren - b_ren), 64'(0));
    chk({nm, "_no_wen"}, 64'(n_wen - b_wen), 64'(0));
    chk({nm, "_no_busy"}, 64'(n_busy - b_busy), 64'(0));
    chk({nm, "_ncfg"}, 64'(n_cfg - b_cfg), 64'(1));
  endtask

  initial begin
    bit seen_wr;
    int b_done;
    HRESET = 1'b1; start = 1'b0; width = '0; length = '0;
    initial_addr_r = '0; initial_addr_w = '0; edge_data = '0;
    repeat (2) @(negedge HCLK);
    chk("reset_outs", 64'(outs()), 64'(0));
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("idle_outs", 64'(outs()), 64'(0));

    run_frame("f3x3", 3, 3, 8'h10, 8'h20, 0, 0, 8'hAB, 1'b0);
    run_frame("f4x3", 4, 3, 8'h11, 8'h21, 0, 0, 8'h3C, 1'b0);
    run_bad("bad_w2", 2, 5);
    run_bad("bad_l0", 5, 0);
    run_frame("stall4x4", 4, 4, 8'h12, 8'h22, 3, 2, 8'hC5, 1'b0);
    run_frame("pert5x4", 5, 4, 8'h13, 8'h23, 0, 0, 8'h5E, 1'b1);

    // reset while a write is pending, then a clean frame
    @(negedge HCLK);
    ack_tied = 1'b1; ev_tied = 1'b1; edge_data = 8'hAB;
    width = 12'd3; length = 12'd3; initial_addr_r = 8'h10; initial_addr_w = 8'h20;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    seen_wr = 1'b0;
    for (int cyc = 0; cyc < 50 && !seen_wr; cyc++) begin
      if (bus.mem_wen) seen_wr = 1'b1;
      else @(negedge HCLK);
    end
    chk("abort_reach_wr", 64'(seen_wr), 64'(1));
    b_done = n_done;
    HRESET = 1'b1;
    #1;
    chk("abort_outs", 64'(outs()), 64'(0));
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);
    chk("abort_no_done", 64'(n_done - b_done), 64'(0));
    chk("abort_idle", 64'(outs()), 64'(0));
    run_frame("post3x3", 3, 3, 8'h30, 8'h40, 0, 0, 8'h77, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
